// File: rtl/iq_frame_streamer.sv
`default_nettype none
// ============================================================================
// iq_frame_streamer : holds one frame of signed IQ samples, streams it on AXIS
// Rev 1.0
// ============================================================================
module iq_frame_streamer #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [index_bits-1:0] wr_addr,
  input  logic [i_bits-1:0]     wr_i,
  input  logic [q_bits-1:0]     wr_q,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  m_axis_tvalid,
  output logic [i_bits-1:0]     xi,
  output logic [q_bits-1:0]     xq,
  output logic [index_bits-1:0] out_index,
  output logic                  tlast,
  input  logic                  s_axis_tready
);

  localparam int                c_w    = i_bits + q_bits;
  localparam logic [index_bits:0] c_len  = (index_bits+1)'(buffer_length);
  localparam logic [index_bits:0] c_last = (index_bits+1)'(buffer_length - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [index_bits:0]   rd_ptr_q, rd_ptr_d;
  logic                  tvalid_q, tvalid_d;
  logic [i_bits-1:0]     xi_q, xi_d;
  logic [q_bits-1:0]     xq_q, xq_d;
  logic [index_bits-1:0] idx_q, idx_d;
  logic                  tlast_q, tlast_d;
  logic [c_w-1:0]        mem_q [buffer_length];
  logic [c_w-1:0]        mem_d [buffer_length];

  logic                  w_wr_ok;
  logic                  w_load;
  logic                  w_xfer;
  logic [c_w-1:0]        w_rd_word;

  always_comb begin
    w_wr_ok   = wr_en && (state_q == ST_IDLE) && ({1'b0, wr_addr} < c_len);
    w_xfer    = tvalid_q && s_axis_tready;
    // rd_ptr is one bit wider, so the bound check stops loads once the frame is issued
    w_load    = (state_q == ST_STREAM) && (!tvalid_q || s_axis_tready) && (rd_ptr_q < c_len);
    w_rd_word = mem_q[rd_ptr_q[index_bits-1:0]];

    mem_d = mem_q;
    if (w_wr_ok) begin
      mem_d[wr_addr] = {wr_i, wr_q};
    end

    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    tvalid_d = tvalid_q;
    xi_d     = xi_q;
    xq_d     = xq_q;
    idx_d    = idx_q;
    tlast_d  = tlast_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_STREAM;
          rd_ptr_d = '0;
        end
      end
      ST_STREAM: begin
        if (w_load) begin
          tvalid_d = 1'b1;
          xi_d     = w_rd_word[c_w-1:q_bits];
          xq_d     = w_rd_word[q_bits-1:0];
          idx_d    = rd_ptr_q[index_bits-1:0];
          tlast_d  = (rd_ptr_q == c_last);
          rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (w_xfer) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      tvalid_q <= 1'b0;
      xi_q     <= '0;
      xq_q     <= '0;
      idx_q    <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      tvalid_q <= tvalid_d;
      xi_q     <= xi_d;
      xq_q     <= xq_d;
      idx_q    <= idx_d;
      tlast_q  <= tlast_d;
    end
  end

  // Sample storage survives reset so a restarted frame replays the same data
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign m_axis_tvalid = tvalid_q;
  assign xi            = xi_q;
  assign xq            = xq_q;
  assign out_index     = idx_q;
  assign tlast         = tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_frame_streamer.sv
`default_nettype none
// ============================================================================
// tb_iq_frame_streamer : scoreboard bench for iq_frame_streamer
// Rev 1.0
// ============================================================================
module tb_iq_frame_streamer;

  localparam int c_len = 10;

  logic              clk = 1'b0;
  logic              rst_n, wr_en, start, s_axis_tready;
  logic              busy, done, m_axis_tvalid, tlast;
  logic [3:0]        wr_addr, out_index;
  logic signed [11:0] wr_i, wr_q, xi, xq;

  always #5 clk = ~clk;

  iq_frame_streamer #(
    .buffer_length(10), .index_bits(4), .i_bits(12), .q_bits(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_i(wr_i),
    .wr_q(wr_q), .start(start), .busy(busy), .done(done),
    .m_axis_tvalid(m_axis_tvalid), .xi(xi), .xq(xq), .out_index(out_index),
    .tlast(tlast), .s_axis_tready(s_axis_tready)
  );

  typedef struct {
    logic signed [11:0] xi;
    logic signed [11:0] xq;
    logic [3:0]         idx;
    logic               last;
  } beat_t;

  typedef struct {
    logic [3:0]         addr;
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic               accept;
  } wvec_t;

  beat_t              exp_q[$];
  beat_t              held, e_b;
  logic signed [11:0] mdl_i [c_len];
  logic signed [11:0] mdl_q [c_len];
  wvec_t              wv [13];

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, neg_cyc = 0, ready_mode = 0;
  int   beats_seen = 0, done_cnt = 0, first_xfer = 0, last_xfer = 0;
  logic mon_en = 1'b0, prev_stall = 1'b0, exp_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       s_axis_tready = 1'b1;
      1:       s_axis_tready = (cyc % 2 == 0);
      default: s_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Output monitor: scoreboard pops, stall stability and done pulse timing
  always @(negedge clk) begin
    neg_cyc++;
    if (mon_en) begin
      check("done_timing", done, exp_done);
      if (done) begin
        done_cnt++;
        check("busy_during_done", busy, 1'b1);
      end
      exp_done = 1'b0;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else if (m_axis_tvalid) begin
        if (prev_stall) begin
          check("stall_xi", xi, held.xi);
          check("stall_xq", xq, held.xq);
          check("stall_index", out_index, held.idx);
          check("stall_tlast", tlast, held.last);
        end
        if (s_axis_tready) begin
          check("beat_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e_b = exp_q.pop_front();
            check("beat_xi", xi, e_b.xi);
            check("beat_xq", xq, e_b.xq);
            check("beat_index", out_index, e_b.idx);
            check("beat_tlast", tlast, e_b.last);
          end
          if (beats_seen == 0) first_xfer = neg_cyc;
          last_xfer = neg_cyc;
          beats_seen++;
          if (tlast) exp_done = 1'b1;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          held.xi   = xi;
          held.xq   = xq;
          held.idx  = out_index;
          held.last = tlast;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic push_frame();
    for (int k = 0; k < c_len; k++) begin
      exp_q.push_back(beat_t'{mdl_i[k], mdl_q[k], 4'(k), (k == c_len - 1)});
    end
  endtask

  task automatic run_frame(input string tag, input int mode, input bit inject, input bit wr0);
    int guard;
    bit injected;
    guard = 0;
    injected = 1'b0;
    ready_mode = mode;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_i = 12'sh7FF; wr_q = 12'sh800;
      mdl_i[0] = 12'sh7FF; mdl_q[0] = 12'sh800;
    end
    push_frame();
    beats_seen = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    check({tag, "_valid_lat0"}, m_axis_tvalid, 1'b0);
    tick();
    check({tag, "_valid_lat1"}, m_axis_tvalid, 1'b1);
    check({tag, "_first_index"}, out_index, 4'd0);
    while (busy && guard < 400) begin
      if (inject && !injected && beats_seen >= 4) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_i = 12'sh123; wr_q = 12'sh456;
        injected = 1'b1;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      guard++;
    end
    check({tag, "_terminated"}, busy, 1'b0);
    check({tag, "_beat_count"}, beats_seen, c_len);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    if (mode == 0) check({tag, "_no_bubbles"}, last_xfer - first_xfer, c_len - 1);
    if (inject) check({tag, "_injected"}, injected, 1'b1);
    repeat (3) tick();
    check({tag, "_stays_idle"}, busy, 1'b0);
  endtask

  initial begin
    int guard;
    for (int k = 0; k < c_len; k++) wv[k] = '{4'(k), 12'(k), 12'(-k), 1'b1};
    wv[10] = '{4'd12, 12'sh555, 12'sh2AA, 1'b0};
    wv[11] = '{4'd10, 12'sh3C3, 12'sh0F0, 1'b0};
    wv[12] = '{4'd15, 12'sh7FF, 12'sh800, 1'b0};
    for (int k = 0; k < c_len; k++) begin
      mdl_i[k] = 12'sh0BD;
      mdl_q[k] = 12'sh0BD;
    end

    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; s_axis_tready = 1'b0;
    wr_addr = '0; wr_i = '0; wr_q = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_xi", xi, 12'h000);
    check("rst_xq", xq, 12'h000);
    check("rst_index", out_index, 4'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int k = 0; k < 13; k++) begin
      wr_en = 1'b1; wr_addr = wv[k].addr; wr_i = wv[k].i; wr_q = wv[k].q;
      if (wv[k].accept) begin
        mdl_i[wv[k].addr] = wv[k].i;
        mdl_q[wv[k].addr] = wv[k].q;
      end
      tick();
    end
    wr_en = 1'b0;
    tick();

    run_frame("full_rate", 0, 1'b0, 1'b0);
    run_frame("odd_stall", 1, 1'b0, 1'b0);
    run_frame("ignore_mid", 2, 1'b1, 1'b0);
    run_frame("mem2_kept", 0, 1'b0, 1'b0);
    run_frame("wr_with_start", 1, 1'b0, 1'b1);

    ready_mode = 2;
    push_frame();
    beats_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (beats_seen < 6 && guard < 200) begin
      tick();
      guard++;
    end
    check("abort_reached_beat5", beats_seen >= 6, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_tvalid", m_axis_tvalid, 1'b0);
    check("abort_tlast", tlast, 1'b0);
    check("abort_xi", xi, 12'h000);
    check("abort_xq", xq, 12'h000);
    check("abort_index", out_index, 4'd0);
    exp_q.delete();
    tick();
    run_frame("after_abort", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
